mem_arbiter: RTL and testbench

Single-port memory arbiter between the core's instruction-fetch port and its load/store port. It owns the one physical memory bus (ROM/RAM/UART/GPIO address space) and serialises fetch and data transactions so that one is outstanding at a time. It returns stall requests to the pipeline controller and abandons a hung transaction with a bus-timeout error. It sits between `core_top`'s `rom_addr_o`/`mem_*` ports and the memory/peripheral fabric.

---
 rtl/mem_arbiter.sv | 177 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: serialises instruction fetches and load/store
// transactions onto one registered memory bus, with flush and bus-timeout handling.
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  input  logic              if_flush_i,
  output logic              if_ack_o,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              if_stall_o,
  input  logic              ls_req_i,
  input  logic              ls_we_i,
  input  logic [ADDR_W-1:0] ls_addr_i,
  input  logic [DATA_W-1:0] ls_wdata_i,
  output logic              ls_ack_o,
  output logic [DATA_W-1:0] ls_rdata_o,
  output logic              ls_stall_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_ready_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              bus_err_o
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  // Abort fires in the busy cycle whose count would reach TIMEOUT.
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DATA  = 2'd2
  } state_t;

  function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] c);
    return (c == {CNT_W{1'b1}}) ? c : c + CNT_W'(1);
  endfunction

  function automatic logic [DATA_W-1:0] rdata_sel(input logic abort,
                                                  input logic [DATA_W-1:0] d);
    return abort ? '0 : d;
  endfunction

  state_t            state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              bus_err_q, bus_err_d;
  logic              flushed_q, flushed_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              busy;
  logic              timeout_hit;
  logic              done;
  logic              fetch_ok;
  logic              ls_done;
  logic [DATA_W-1:0] rdata_eff;
  logic              grant_ls;
  logic              grant_if;
  logic              go_idle;

  always_comb begin
    busy        = (state_q != IDLE);
    timeout_hit = (TIMEOUT != 0) && busy && !mem_ready_i && (cnt_q == CNT_LAST);
    done        = busy && (mem_ready_i || timeout_hit);
    rdata_eff   = rdata_sel(timeout_hit, mem_rdata_i);
    // A flush on the completion cycle itself still drops the fetch.
    fetch_ok    = (state_q == FETCH) && done && !flushed_q && !if_flush_i;
    ls_done     = (state_q == DATA) && done;

    if_ack_o    = fetch_ok;
    if_rdata_o  = fetch_ok ? rdata_eff : '0;
    ls_ack_o    = ls_done;
    ls_rdata_o  = (ls_done && !mem_we_q) ? rdata_eff : '0;
    if_stall_o  = rst_n & if_req_i & ~fetch_ok;
    ls_stall_o  = rst_n & ls_req_i & ~ls_done;
  end

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    flushed_d   = flushed_q;
    cnt_d       = cnt_q;
    bus_err_d   = timeout_hit;
    grant_ls    = 1'b0;
    grant_if    = 1'b0;
    go_idle     = 1'b0;

    // The requester that just completed is masked, so contention alternates.
    case (state_q)
      IDLE: begin
        if (ls_req_i)      grant_ls = 1'b1;
        else if (if_req_i) grant_if = 1'b1;
      end
      FETCH: begin
        if (done) begin
          if (ls_req_i) grant_ls = 1'b1;
          else          go_idle  = 1'b1;
        end else begin
          flushed_d = flushed_q | if_flush_i;
          cnt_d     = cnt_sat_inc(cnt_q);
        end
      end
      DATA: begin
        if (done) begin
          if (if_req_i) grant_if = 1'b1;
          else          go_idle  = 1'b1;
        end else begin
          cnt_d = cnt_sat_inc(cnt_q);
        end
      end
      default: go_idle = 1'b1;
    endcase

    if (grant_ls) begin
      state_d     = DATA;
      mem_req_d   = 1'b1;
      mem_we_d    = ls_we_i;
      mem_addr_d  = ls_addr_i;
      mem_wdata_d = ls_wdata_i;
      flushed_d   = 1'b0;
      cnt_d       = '0;
    end else if (grant_if) begin
      state_d     = FETCH;
      mem_req_d   = 1'b1;
      mem_we_d    = 1'b0;
      mem_addr_d  = if_addr_i;
      flushed_d   = 1'b0;
      cnt_d       = '0;
    end else if (go_idle) begin
      state_d     = IDLE;
      mem_req_d   = 1'b0;
      flushed_d   = 1'b0;
      cnt_d       = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      bus_err_q   <= 1'b0;
      flushed_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      bus_err_q   <= bus_err_d;
      flushed_q   <= flushed_d;
      cnt_q       <= cnt_d;
    end
  end

  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign bus_err_o   = bus_err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: fetch, contention, flush, timeout and reset.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, if_flush, if_ack, if_stall;
  logic [31:0] if_addr, if_rdata;
  logic        ls_req, ls_we, ls_ack, ls_stall;
  logic [31:0] ls_addr, ls_wdata, ls_rdata;
  logic        mem_req, mem_we, mem_ready, bus_err;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int n_cmp = 0;
  int n_err = 0;
  int if_acks, ls_acks;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_flush_i(if_flush),
    .if_ack_o(if_ack), .if_rdata_o(if_rdata), .if_stall_o(if_stall),
    .ls_req_i(ls_req), .ls_we_i(ls_we), .ls_addr_i(ls_addr), .ls_wdata_i(ls_wdata),
    .ls_ack_o(ls_ack), .ls_rdata_o(ls_rdata), .ls_stall_o(ls_stall),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_ready_i(mem_ready), .mem_rdata_i(mem_rdata),
    .bus_err_o(bus_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; if_flush = 1'b0; mem_ready = 1'b0; mem_rdata = '0;
    if_req = 1'b1; if_addr = 32'h40;
    ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h10; ls_wdata = 32'h5;

    // Under reset: registers clear, combinational stalls forced low
    mid();
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_mem_we", mem_we, 1'b0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_bus_err", bus_err, 1'b0);
    chk("rst_if_stall", if_stall, 1'b0);
    chk("rst_ls_stall", ls_stall, 1'b0);
    chk("rst_if_ack", if_ack, 1'b0);
    nxt();
    rst_n = 1'b1; if_req = 1'b0; ls_req = 1'b0; ls_we = 1'b0;
    mid();
    chk("idle_mem_req", mem_req, 1'b0);
    nxt();

    // Uncontended fetch, zero wait
    if_req = 1'b1; if_addr = 32'h0000_0040;
    mid();
    chk("f1_stall_req", if_stall, 1'b1);
    chk("f1_req_pre", mem_req, 1'b0);
    nxt();
    mem_ready = 1'b1; mem_rdata = 32'h0010_0093;
    mid();
    chk("f1_mem_req", mem_req, 1'b1);
    chk("f1_mem_addr", mem_addr, 32'h40);
    chk("f1_mem_we", mem_we, 1'b0);
    chk("f1_ack", if_ack, 1'b1);
    chk("f1_rdata", if_rdata, 32'h0010_0093);
    chk("f1_stall_ack", if_stall, 1'b0);
    nxt();
    if_req = 1'b0; mem_ready = 1'b0;
    mid();
    chk("f1_idle_req", mem_req, 1'b0);
    chk("f1_idle_stall", if_stall, 1'b0);
    nxt();

    // Simultaneous store and fetch: data first, then fetch with no bubble
    if_req = 1'b1; if_addr = 32'h80;
    ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h1000; ls_wdata = 32'hDEAD_BEEF;
    mid();
    chk("c_if_stall0", if_stall, 1'b1);
    chk("c_ls_stall0", ls_stall, 1'b1);
    nxt();
    mem_ready = 1'b1; mem_rdata = 32'h1234_5678;
    mid();
    chk("c_we", mem_we, 1'b1);
    chk("c_addr", mem_addr, 32'h1000);
    chk("c_wdata", mem_wdata, 32'hDEAD_BEEF);
    chk("c_ls_ack", ls_ack, 1'b1);
    chk("c_st_rdata", ls_rdata, 32'h0);
    chk("c_if_ack0", if_ack, 1'b0);
    chk("c_if_stall1", if_stall, 1'b1);
    nxt();
    ls_req = 1'b0; ls_we = 1'b0; mem_ready = 1'b0;
    mid();
    chk("c_nobubble_req", mem_req, 1'b1);
    chk("c_f_addr", mem_addr, 32'h80);
    chk("c_f_we", mem_we, 1'b0);
    chk("c_if_stall2", if_stall, 1'b1);
    nxt();
    mem_ready = 1'b1; mem_rdata = 32'hAAAA_0001;
    mid();
    chk("c_if_ack", if_ack, 1'b1);
    chk("c_if_rdata", if_rdata, 32'hAAAA_0001);
    nxt();
    if_req = 1'b0; mem_ready = 1'b0;
    mid();
    chk("c_idle", mem_req, 1'b0);
    nxt();

    // Sustained contention: 10 transactions alternating DATA/FETCH
    if_req = 1'b1; if_addr = 32'h100;
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h3000;
    mem_ready = 1'b1; mem_rdata = 32'hC000_0000;
    mid();
    chk("s_idle_noack", ls_ack, 1'b0);
    nxt();
    if_acks = 0; ls_acks = 0;
    for (int k = 1; k <= 10; k++) begin
      if (k == 10) ls_req = 1'b0;
      mem_rdata = 32'hC000_0000 + k;
      mid();
      if (ls_ack) ls_acks++;
      if (if_ack) if_acks++;
      chk("s_ls_ack", ls_ack, (k % 2 == 1));
      chk("s_if_ack", if_ack, (k % 2 == 0));
      chk("s_addr", mem_addr, (k % 2 == 1) ? 32'h3000 : 32'h100);
      chk("s_rdata", (k % 2 == 1) ? ls_rdata : if_rdata, 32'hC000_0000 + k);
      nxt();
    end
    if_req = 1'b0; mem_ready = 1'b0;
    mid();
    chk("s_ls_total", ls_acks, 5);
    chk("s_if_total", if_acks, 5);
    chk("s_idle", mem_req, 1'b0);
    nxt();

    // Flush during FETCH, ready three cycles later
    if_req = 1'b1; if_addr = 32'h200;
    mid();
    nxt();
    if_flush = 1'b1;
    mid();
    chk("fl_ack0", if_ack, 1'b0);
    chk("fl_addr", mem_addr, 32'h200);
    nxt();
    if_flush = 1'b0; if_addr = 32'h300;
    mid();
    chk("fl_addr_stable", mem_addr, 32'h200);
    nxt();
    mid();
    nxt();
    mem_ready = 1'b1; mem_rdata = 32'hBAD0_BAD0;
    mid();
    chk("fl_noack", if_ack, 1'b0);
    chk("fl_stall", if_stall, 1'b1);
    nxt();
    mem_ready = 1'b0;
    mid();
    chk("fl_idle", mem_req, 1'b0);
    nxt();
    mem_ready = 1'b1; mem_rdata = 32'h0000_0013;
    mid();
    chk("fl_new_req", mem_req, 1'b1);
    chk("fl_new_addr", mem_addr, 32'h300);
    chk("fl_new_ack", if_ack, 1'b1);
    chk("fl_new_rdata", if_rdata, 32'h13);
    nxt();
    // Flush on the completion cycle itself
    if_addr = 32'h304; mem_ready = 1'b0;
    mid();
    chk("fc_idle", mem_req, 1'b0);
    nxt();
    mem_ready = 1'b1; if_flush = 1'b1;
    mid();
    chk("fc_addr", mem_addr, 32'h304);
    chk("fc_noack", if_ack, 1'b0);
    nxt();
    if_req = 1'b0; if_flush = 1'b0; mem_ready = 1'b0;
    mid();
    chk("fc_idle2", mem_req, 1'b0);
    nxt();

    // Timeout on a load with ready held low
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h2000; mem_rdata = 32'hFFFF_FFFF;
    mid();
    chk("t_stall", ls_stall, 1'b1);
    nxt();
    for (int b = 1; b <= 15; b++) begin
      mid();
      chk("t_ack", ls_ack, (b == 15));
      if (b == 15) begin
        chk("t_rdata0", ls_rdata, 32'h0);
        chk("t_err_early", bus_err, 1'b0);
        chk("t_addr", mem_addr, 32'h2000);
      end
      nxt();
    end
    ls_req = 1'b0; if_req = 1'b1; if_addr = 32'h400;
    mid();
    chk("t_err_pulse", bus_err, 1'b1);
    chk("t_idle", mem_req, 1'b0);
    nxt();
    mem_ready = 1'b1; mem_rdata = 32'h55;
    mid();
    chk("t_err_clr", bus_err, 1'b0);
    chk("t_next_addr", mem_addr, 32'h400);
    chk("t_next_ack", if_ack, 1'b1);
    nxt();
    if_req = 1'b0; mem_ready = 1'b0;
    mid();
    nxt();

    // Reset asserted mid-DATA
    ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h5000; ls_wdata = 32'h1234;
    mid();
    nxt();
    mid();
    chk("r_busy", mem_req, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("r_async_req", mem_req, 1'b0);
    chk("r_async_we", mem_we, 1'b0);
    chk("r_async_addr", mem_addr, 32'h0);
    chk("r_ls_stall", ls_stall, 1'b0);
    ls_req = 1'b0; ls_we = 1'b0;
    nxt();
    rst_n = 1'b1; if_req = 1'b1; if_addr = 32'h600;
    mid();
    chk("r_idle", mem_req, 1'b0);
    chk("r_if_stall", if_stall, 1'b1);
    nxt();
    mem_ready = 1'b1; mem_rdata = 32'h77;
    mid();
    chk("r_req", mem_req, 1'b1);
    chk("r_addr", mem_addr, 32'h600);
    chk("r_we", mem_we, 1'b0);
    chk("r_ack", if_ack, 1'b1);
    chk("r_rdata", if_rdata, 32'h77);
    nxt();
    if_req = 1'b0; mem_ready = 1'b0;
    mid();
    chk("r_end_idle", mem_req, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
